route_compute_pipe: RTL and testbench

ROUTE_COMPUTE_PIPE -- requirements
Module: route_compute_pipe

---
 rtl/noc_pkg.sv | 49 ++++
 rtl/route_compute_pipe_if.sv | 28 ++
 rtl/xy_route_calc.sv | 55 +++++
 rtl/route_compute_pipe.sv | 141 ++++++++++++++
 tb/tb_route_compute_pipe.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: port codes, flit types, one-hot bit positions and FSM states.
package noc_pkg;

    localparam int unsigned PORT_NUM_W = 4;
    localparam int unsigned PORT_OH_W  = 5;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned TYPE_W     = 2;

    localparam logic [PORT_NUM_W-1:0] PORT_NONE = 4'd0;
    localparam logic [PORT_NUM_W-1:0] PORT_L    = 4'd1;
    localparam logic [PORT_NUM_W-1:0] PORT_E    = 4'd2;
    localparam logic [PORT_NUM_W-1:0] PORT_N    = 4'd3;
    localparam logic [PORT_NUM_W-1:0] PORT_W    = 4'd4;
    localparam logic [PORT_NUM_W-1:0] PORT_S    = 4'd5;

    localparam int unsigned OH_L = 0;
    localparam int unsigned OH_E = 1;
    localparam int unsigned OH_W = 2;
    localparam int unsigned OH_S = 3;
    localparam int unsigned OH_N = 4;

    typedef enum logic [TYPE_W-1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_TAIL     = 2'b01,
        FLIT_HDR      = 2'b10,
        FLIT_HDR_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } rc_state_e;

    // Route code to one-hot output vector; unknown codes map to all-zero.
    function automatic logic [PORT_OH_W-1:0] port_onehot(input logic [PORT_NUM_W-1:0] p);
        logic [PORT_OH_W-1:0] oh;
        oh = '0;
        case (p)
            PORT_L:  oh[OH_L] = 1'b1;
            PORT_E:  oh[OH_E] = 1'b1;
            PORT_W:  oh[OH_W] = 1'b1;
            PORT_S:  oh[OH_S] = 1'b1;
            PORT_N:  oh[OH_N] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/route_compute_pipe_if.sv
// Bundled flit handshake and route-result signals of route_compute_pipe.
interface route_compute_pipe_if #(
    parameter int unsigned FLIT_W = 8
) ();
    import noc_pkg::*;

    logic [FLIT_W-1:0]     in_flit;
    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_W-1:0]     out_flit;
    logic                  out_valid;
    logic                  out_ready;
    logic [PORT_NUM_W-1:0] port_num;
    logic [PORT_OH_W-1:0]  port_oh;
    logic                  err;
    logic [CNT_W-1:0]      pkt_cnt;

    modport master (
        output in_flit, in_valid, out_ready,
        input  in_ready, out_flit, out_valid, port_num, port_oh, err, pkt_cnt
    );

    modport slave (
        input  in_flit, in_valid, out_ready,
        output in_ready, out_flit, out_valid, port_num, port_oh, err, pkt_cnt
    );

endinterface

// File: rtl/xy_route_calc.sv
// Combinational dimension-order route decision for one destination coordinate pair.
module xy_route_calc
    import noc_pkg::*;
#(
    parameter int unsigned X_NODE_NUM = 4,
    parameter int unsigned Y_NODE_NUM = 4,
    parameter int unsigned X_CUR      = 0,
    parameter int unsigned Y_CUR      = 1,
    parameter int unsigned X_W        = 2,
    parameter int unsigned Y_W        = 2,
    parameter int unsigned ROUTING    = 0
) (
    input  logic [X_W-1:0]        dest_x,
    input  logic [Y_W-1:0]        dest_y,
    output logic [PORT_NUM_W-1:0] port_num,
    output logic                  range_err
);

    localparam logic [X_W:0] X_CUR_EXT = (X_W+1)'(X_CUR);
    localparam logic [Y_W:0] Y_CUR_EXT = (Y_W+1)'(Y_CUR);
    localparam logic [X_W:0] X_LIM     = (X_W+1)'(X_NODE_NUM);
    localparam logic [Y_W:0] Y_LIM     = (Y_W+1)'(Y_NODE_NUM);

    logic signed [X_W:0]   dx_c;
    logic signed [Y_W:0]   dy_c;
    logic [PORT_NUM_W-1:0] x_port_c;
    logic [PORT_NUM_W-1:0] y_port_c;

    always_comb begin
        dx_c      = $signed({1'b0, dest_x}) - $signed(X_CUR_EXT);
        dy_c      = $signed({1'b0, dest_y}) - $signed(Y_CUR_EXT);
        x_port_c  = PORT_NONE;
        y_port_c  = PORT_NONE;
        range_err = ({1'b0, dest_x} >= X_LIM) || ({1'b0, dest_y} >= Y_LIM);

        // Sign bit set means negative; non-zero with clear sign means positive.
        if (dx_c[X_W])            x_port_c = PORT_W;
        else if (dx_c != '0)      x_port_c = PORT_E;
        if (dy_c[Y_W])            y_port_c = PORT_N;
        else if (dy_c != '0)      y_port_c = PORT_S;

        if (ROUTING == 0) begin
            if (x_port_c != PORT_NONE)      port_num = x_port_c;
            else if (y_port_c != PORT_NONE) port_num = y_port_c;
            else                            port_num = PORT_L;
        end else begin
            if (y_port_c != PORT_NONE)      port_num = y_port_c;
            else if (x_port_c != PORT_NONE) port_num = x_port_c;
            else                            port_num = PORT_L;
        end

        if (range_err) port_num = PORT_NONE;
    end

endmodule

// File: rtl/route_compute_pipe.sv
// One-stage flit pipeline that computes, latches and tags each packet with its output port.
module route_compute_pipe
    import noc_pkg::*;
#(
    parameter int unsigned X_NODE_NUM = 4,
    parameter int unsigned Y_NODE_NUM = 4,
    parameter int unsigned X_CUR      = 0,
    parameter int unsigned Y_CUR      = 1,
    parameter int unsigned FLIT_W     = 8,
    parameter int unsigned ROUTING    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_W-1:0]     in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_W-1:0]     out_flit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PORT_NUM_W-1:0] port_num,
    output logic [PORT_OH_W-1:0]  port_oh,
    output logic                  err,
    output logic [CNT_W-1:0]      pkt_cnt
);

    localparam int unsigned X_W = (X_NODE_NUM > 2) ? $clog2(X_NODE_NUM) : 1;
    localparam int unsigned Y_W = (Y_NODE_NUM > 2) ? $clog2(Y_NODE_NUM) : 1;

    rc_state_e             state_q, state_d;
    logic [FLIT_W-1:0]     out_flit_q, out_flit_d;
    logic                  out_valid_q, out_valid_d;
    logic [PORT_NUM_W-1:0] port_num_q, port_num_d;
    logic [PORT_OH_W-1:0]  port_oh_q;
    logic [PORT_NUM_W-1:0] route_q, route_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;

    flit_type_e            flit_type_c;
    logic                  accept_c;
    logic                  fwd_c;
    logic                  tail_c;
    logic [PORT_NUM_W-1:0] fwd_port_c;
    logic [PORT_NUM_W-1:0] calc_port_c;
    logic                  calc_err_c;

    assign in_ready    = !out_valid_q || out_ready;
    assign accept_c    = in_valid && in_ready;
    assign flit_type_c = flit_type_e'(in_flit[FLIT_W-1 -: TYPE_W]);

    xy_route_calc #(
        .X_NODE_NUM (X_NODE_NUM),
        .Y_NODE_NUM (Y_NODE_NUM),
        .X_CUR      (X_CUR),
        .Y_CUR      (Y_CUR),
        .X_W        (X_W),
        .Y_W        (Y_W),
        .ROUTING    (ROUTING)
    ) u_calc (
        .dest_x    (in_flit[Y_W +: X_W]),
        .dest_y    (in_flit[0 +: Y_W]),
        .port_num  (calc_port_c),
        .range_err (calc_err_c)
    );

    // Packet FSM, forwarding decision and packet counter.
    always_comb begin
        state_d     = state_q;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q;
        port_num_d  = port_num_q;
        route_d     = route_q;
        err_d       = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        fwd_c       = 1'b0;
        tail_c      = 1'b0;
        fwd_port_c  = PORT_NONE;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (accept_c) begin
            case (flit_type_c)
                FLIT_HDR, FLIT_HDR_TAIL: begin
                    // A header seen mid-packet restarts the packet but is flagged.
                    fwd_c      = 1'b1;
                    fwd_port_c = calc_port_c;
                    route_d    = calc_port_c;
                    err_d      = calc_err_c || (state_q == ST_BUSY);
                    tail_c     = (flit_type_c == FLIT_HDR_TAIL);
                    state_d    = (flit_type_c == FLIT_HDR) ? ST_BUSY : ST_IDLE;
                end
                default: begin
                    if (state_q == ST_BUSY) begin
                        fwd_c      = 1'b1;
                        fwd_port_c = route_q;
                        tail_c     = (flit_type_c == FLIT_TAIL);
                        if (tail_c) state_d = ST_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase

            if (fwd_c) begin
                out_flit_d  = in_flit;
                out_valid_d = 1'b1;
                port_num_d  = fwd_port_c;
            end
            if (tail_c && (pkt_cnt_q != '1)) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
            port_num_q  <= PORT_NONE;
            port_oh_q   <= '0;
            route_q     <= PORT_NONE;
            err_q       <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
            port_num_q  <= port_num_d;
            port_oh_q   <= port_onehot(port_num_d);
            route_q     <= route_d;
            err_q       <= err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign out_flit  = out_flit_q;
    assign out_valid = out_valid_q;
    assign port_num  = port_num_q;
    assign port_oh   = port_oh_q;
    assign err       = err_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_route_compute_pipe.sv
// Directed bench: XY instance at (0,1) on 4x4, plus a YX instance on a 5x4 mesh for range errors.
module tb_route_compute_pipe;
    import noc_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    route_compute_pipe_if #(.FLIT_W(8)) ifa ();
    route_compute_pipe_if #(.FLIT_W(8)) ifb ();

    route_compute_pipe #(
        .X_NODE_NUM(4), .Y_NODE_NUM(4), .X_CUR(0), .Y_CUR(1), .FLIT_W(8), .ROUTING(0)
    ) dut_a (
        .clk(clk), .rst(rst),
        .in_flit(ifa.in_flit), .in_valid(ifa.in_valid), .in_ready(ifa.in_ready),
        .out_flit(ifa.out_flit), .out_valid(ifa.out_valid), .out_ready(ifa.out_ready),
        .port_num(ifa.port_num), .port_oh(ifa.port_oh), .err(ifa.err), .pkt_cnt(ifa.pkt_cnt)
    );

    route_compute_pipe #(
        .X_NODE_NUM(5), .Y_NODE_NUM(4), .X_CUR(0), .Y_CUR(1), .FLIT_W(8), .ROUTING(1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_flit(ifb.in_flit), .in_valid(ifb.in_valid), .in_ready(ifb.in_ready),
        .out_flit(ifb.out_flit), .out_valid(ifb.out_valid), .out_ready(ifb.out_ready),
        .port_num(ifb.port_num), .port_oh(ifb.port_oh), .err(ifb.err), .pkt_cnt(ifb.pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] f);
        @(negedge clk);
        ifa.in_flit  = f;
        ifa.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] f);
        @(negedge clk);
        ifb.in_flit  = f;
        ifb.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifb.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rst = 1'b0; checks = 0; failures = 0;
        ifa.in_flit = '0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_flit = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_flit",  ifa.out_flit,  0);
        chk("rst_port_num",  ifa.port_num,  0);
        chk("rst_port_oh",   ifa.port_oh,   0);
        chk("rst_err",       ifa.err,       0);
        chk("rst_pkt_cnt",   ifa.pkt_cnt,   0);
        chk("rst_b_valid",   ifb.out_valid, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", ifa.in_ready, 1);

        // XY packet to (2,1): east for all three flits
        send_a(8'h89);
        chk("hdr_valid", ifa.out_valid, 1);
        chk("hdr_flit",  ifa.out_flit,  8'h89);
        chk("hdr_port",  ifa.port_num,  2);
        chk("hdr_oh",    ifa.port_oh,   5'b00010);
        chk("hdr_err",   ifa.err,       0);
        chk("hdr_state", dut_a.state_q, ST_BUSY);
        send_a(8'h3C);
        chk("body_flit", ifa.out_flit,  8'h3C);
        chk("body_port", ifa.port_num,  2);
        chk("body_oh",   ifa.port_oh,   5'b00010);
        send_a(8'h55);
        chk("tail_flit",  ifa.out_flit,  8'h55);
        chk("tail_port",  ifa.port_num,  2);
        chk("tail_oh",    ifa.port_oh,   5'b00010);
        chk("tail_cnt",   ifa.pkt_cnt,   1);
        chk("tail_state", dut_a.state_q, ST_IDLE);

        // Directions: south, north, local
        send_a(8'hC3);
        chk("dir_s_port", ifa.port_num, 5);
        chk("dir_s_oh",   ifa.port_oh,  5'b01000);
        send_a(8'hC0);
        chk("dir_n_port", ifa.port_num, 3);
        chk("dir_n_oh",   ifa.port_oh,  5'b10000);
        send_a(8'hC1);
        chk("dir_l_port", ifa.port_num, 1);
        chk("dir_l_oh",   ifa.port_oh,  5'b00001);
        chk("dir_l_err",  ifa.err,      0);
        chk("dir_cnt",    ifa.pkt_cnt,  4);

        // YX to (3,3): Y resolved first, so south rather than east
        send_b(8'hCF);
        chk("yx_port",  ifb.port_num, 5);
        chk("yx_oh",    ifb.port_oh,  5'b01000);
        chk("yx_cnt",   ifb.pkt_cnt,  1);

        // Backpressure: header held while sink stalls, body follows release
        @(negedge clk);
        ifa.out_ready = 1'b0;
        ifa.in_flit   = 8'h89;
        ifa.in_valid  = 1'b1;
        @(posedge clk); #1;
        chk("bp_hdr_valid", ifa.out_valid, 1);
        chk("bp_hdr_flit",  ifa.out_flit,  8'h89);
        ifa.in_flit = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", ifa.in_ready,  0);
            chk("bp_hold_flit", ifa.out_flit, 8'h89);
            chk("bp_hold_port", ifa.port_num, 2);
            chk("bp_hold_valid", ifa.out_valid, 1);
        end
        @(negedge clk); ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        chk("bp_body_flit",  ifa.out_flit,  8'h3C);
        chk("bp_body_valid", ifa.out_valid, 1);
        chk("bp_body_port",  ifa.port_num,  2);
        send_a(8'h55);
        chk("bp_tail_flit", ifa.out_flit, 8'h55);
        chk("bp_cnt",       ifa.pkt_cnt,  5);

        // BODY while idle: dropped with a single-cycle err
        send_a(8'h3C);
        chk("drop_valid", ifa.out_valid, 0);
        chk("drop_err",   ifa.err,       1);
        chk("drop_cnt",   ifa.pkt_cnt,   5);
        @(posedge clk); #1;
        chk("drop_err_pulse", ifa.err, 0);

        // Out-of-range header (5,0) on the 5-column mesh, then its tail
        send_b(8'h94);
        chk("rng_valid", ifb.out_valid, 1);
        chk("rng_flit",  ifb.out_flit,  8'h94);
        chk("rng_port",  ifb.port_num,  0);
        chk("rng_oh",    ifb.port_oh,   0);
        chk("rng_err",   ifb.err,       1);
        send_b(8'h40);
        chk("rng_tail_valid", ifb.out_valid, 1);
        chk("rng_tail_port",  ifb.port_num,  0);
        chk("rng_tail_err",   ifb.err,       0);
        chk("rng_tail_cnt",   ifb.pkt_cnt,   2);

        // Header while busy: restart flagged as error
        send_a(8'h89);
        send_a(8'hC0);
        chk("rehdr_err",   ifa.err,       1);
        chk("rehdr_port",  ifa.port_num,  3);
        chk("rehdr_state", dut_a.state_q, ST_IDLE);
        chk("rehdr_cnt",   ifa.pkt_cnt,   6);

        // Mid-packet reset
        send_a(8'h89);
        chk("mid_busy", dut_a.state_q, ST_BUSY);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("mid_rst_valid", ifa.out_valid, 0);
        chk("mid_rst_flit",  ifa.out_flit,  0);
        chk("mid_rst_port",  ifa.port_num,  0);
        chk("mid_rst_oh",    ifa.port_oh,   0);
        chk("mid_rst_cnt",   ifa.pkt_cnt,   0);
        chk("mid_rst_state", dut_a.state_q, ST_IDLE);
        @(negedge clk); rst = 1'b1;
        send_a(8'h55);
        chk("mid_tail_valid", ifa.out_valid, 0);
        chk("mid_tail_err",   ifa.err,       1);
        chk("mid_tail_cnt",   ifa.pkt_cnt,   0);

        // Counter saturation
        @(negedge clk);
        force dut_a.pkt_cnt_q = 16'hFFFE;
        #1;
        release dut_a.pkt_cnt_q;
        chk("sat_preload", ifa.pkt_cnt, 16'hFFFE);
        send_a(8'hC1);
        chk("sat_first",  ifa.pkt_cnt, 16'hFFFF);
        send_a(8'hC1);
        chk("sat_second", ifa.pkt_cnt, 16'hFFFF);
        chk("sat_port",   ifa.port_num, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
